// File: rtl/memory_dp.sv
// memory_dp: simple-dual-port RAM with a registered read port, selectable
// read-during-write behaviour and a clear sequencer that zeroes the whole
// array after every reset. Requests are dropped while the clear runs.
module memory_dp #(
  parameter int addr_size   = 10,
  parameter int word_size   = 8,
  parameter int memory_size = 1024,
  parameter bit wr_first    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic                 wr_i,
  input  logic [addr_size-1:0] wr_addr_i,
  input  logic [word_size-1:0] data_in_i,
  input  logic                 rd_i,
  input  logic [addr_size-1:0] rd_addr_i,
  output logic [word_size-1:0] data_out_o,
  output logic                 valid_o,
  output logic                 busy_o
);

  // Index width of the physical array; never wider than the address port.
  localparam int IDX_W = (memory_size > 1) ? $clog2(memory_size) : 1;
  // One extra bit so the limit is representable when memory_size == 2^addr_size.
  localparam logic [addr_size:0] MEM_LIM  = (addr_size + 1)'(memory_size);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(memory_size - 1);

  // CLEAR is encoded as 1 so the state flop doubles as the busy flag.
  localparam logic [0:0] STATE_READY = 1'b0;
  localparam logic [0:0] STATE_CLEAR = 1'b1;

  logic [0:0]           state_q;
  logic [0:0]           state_d;
  logic [IDX_W-1:0]     clr_ptr_q;
  logic [IDX_W-1:0]     clr_ptr_d;
  logic [word_size-1:0] data_out_q;
  logic [word_size-1:0] data_out_d;
  logic                 valid_q;
  logic                 valid_d;

  logic [word_size-1:0] mem_q [0:memory_size-1];

  logic                 ready_s;
  logic                 wr_in_range_s;
  logic                 rd_in_range_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic                 same_addr_s;
  logic [IDX_W-1:0]     wr_idx_s;
  logic [IDX_W-1:0]     rd_idx_s;

  // Request decode: out-of-range addresses are caught before truncation so
  // they can never alias onto low words.
  always_comb begin
    ready_s       = (state_q == STATE_READY);
    wr_in_range_s = ({1'b0, wr_addr_i} < MEM_LIM);
    rd_in_range_s = ({1'b0, rd_addr_i} < MEM_LIM);
    wr_idx_s      = wr_addr_i[IDX_W-1:0];
    rd_idx_s      = rd_addr_i[IDX_W-1:0];
    wr_en_s       = ready_s & cs_i & wr_i & wr_in_range_s;
    rd_en_s       = ready_s & cs_i & rd_i;
    same_addr_s   = (wr_addr_i == rd_addr_i);
  end

  // Clear sequencer: walk every word once, then hand over to normal use.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      STATE_CLEAR: begin
        if (clr_ptr_q == LAST_IDX) begin
          state_d   = STATE_READY;
          clr_ptr_d = {IDX_W{1'b0}};
        end else begin
          state_d   = STATE_CLEAR;
          clr_ptr_d = clr_ptr_q + IDX_W'(1);
        end
      end
      STATE_READY: begin
        state_d   = STATE_READY;
        clr_ptr_d = clr_ptr_q;
      end
      default: begin
        state_d   = STATE_CLEAR;
        clr_ptr_d = {IDX_W{1'b0}};
      end
    endcase
  end

  // Read path: out-of-range reads return zero; a same-address write is
  // forwarded only in write-first mode, otherwise the old word is returned.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    if (rd_en_s) begin
      valid_d = 1'b1;
      if (!rd_in_range_s) begin
        data_out_d = {word_size{1'b0}};
      end else if (wr_first && wr_en_s && same_addr_s) begin
        data_out_d = data_in_i;
      end else begin
        data_out_d = mem_q[rd_idx_s];
      end
    end else begin
      valid_d    = 1'b0;
      data_out_d = data_out_q;
    end
  end

  // Storage array: the clear sequencer owns the write port while busy.
  always_ff @(posedge clk_i) begin
    if (state_q == STATE_CLEAR) begin
      mem_q[clr_ptr_q] <= {word_size{1'b0}};
    end else if (wr_en_s) begin
      mem_q[wr_idx_s] <= data_in_i;
    end
  end

  // Control and output registers with asynchronous reset into CLEAR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= STATE_CLEAR;
      clr_ptr_q  <= {IDX_W{1'b0}};
      data_out_q <= {word_size{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out_o = data_out_q;
  assign valid_o    = valid_q;
  assign busy_o     = state_q;

endmodule
